// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: binary-angle arctangent table, quadrant offsets,
// gain-compensation factor and the vectoring FSM state encoding.
package cordic_pkg;

    localparam logic [31:0] ANG_P90      = 32'h4000_0000;
    localparam logic [31:0] ANG_M90      = 32'hC000_0000;
    localparam logic [15:0] CORDIC_K_Q16 = 16'h9B75;

    // round(atan(2^-i) * 2^32 / (2*pi)); 2^32 is one full turn
    localparam logic [31:0] ATAN_TBL [31] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_SCALE = 2'd2,
        ST_DONE  = 2'd3
    } cv_state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: 5-bit micro-rotation index to 32-bit
// binary angle. Index 31 is outside the table and returns zero.
module cordic_atan_rom (
    input  logic [4:0]  i_idx,
    output logic [31:0] o_atan
);
    import cordic_pkg::*;

    always_comb begin
        o_atan = '0;
        if (i_idx != 5'd31) begin
            o_atan = ATAN_TBL[i_idx];
        end
    end

endmodule

// File: rtl/cordic_vector.sv
// Iterative CORDIC vectoring engine: (Xin,Yin) -> magnitude and binary angle, one micro-rotation
// per clock; latency ITER cycles (+1 with CORDIC_VEC_GAIN_COMP_EN); in_ready low from accept to output handshake.
module cordic_vector #(
    parameter int XY_SZ = 16,
    parameter int ITER  = XY_SZ
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [XY_SZ-1:0] Xin,
    input  logic signed [XY_SZ-1:0] Yin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XY_SZ:0]          Mag,
    output logic [31:0]             Angle
);
    import cordic_pkg::*;

    localparam int W = XY_SZ + 2;

    cv_state_t         r_state;
    cv_state_t         w_state_nxt;
    logic signed [W-1:0] r_x;
    logic signed [W-1:0] r_y;
    logic [31:0]       r_z;
    logic [4:0]        r_cnt;
    logic              r_zero;
    logic [XY_SZ:0]    r_mag;
    logic [31:0]       r_ang;

    logic signed [W-1:0] w_xin_ext;
    logic signed [W-1:0] w_yin_ext;
    logic signed [W-1:0] w_x_pre;
    logic signed [W-1:0] w_y_pre;
    logic [31:0]       w_z_pre;
    logic signed [W-1:0] w_x_sh;
    logic signed [W-1:0] w_y_sh;
    logic signed [W-1:0] w_x_nxt;
    logic signed [W-1:0] w_y_nxt;
    logic [31:0]       w_z_nxt;
    logic [31:0]       w_atan;
    logic              w_last;

    cordic_atan_rom u_atan_rom (
        .i_idx  (r_cnt),
        .o_atan (w_atan)
    );

    // Fold the left half-plane into the right one so the micro-rotations converge.
    always_comb begin
        w_xin_ext = {{2{Xin[XY_SZ-1]}}, Xin};
        w_yin_ext = {{2{Yin[XY_SZ-1]}}, Yin};
        if (!Xin[XY_SZ-1]) begin
            w_x_pre = w_xin_ext;
            w_y_pre = w_yin_ext;
            w_z_pre = '0;
        end else if (!Yin[XY_SZ-1]) begin
            w_x_pre = w_yin_ext;
            w_y_pre = -w_xin_ext;
            w_z_pre = ANG_P90;
        end else begin
            w_x_pre = -w_yin_ext;
            w_y_pre = w_xin_ext;
            w_z_pre = ANG_M90;
        end
    end

    always_comb begin
        w_x_sh = r_x >>> r_cnt;
        w_y_sh = r_y >>> r_cnt;
        w_last = (r_cnt == 5'(ITER - 1));
        if (r_y[W-1]) begin
            w_x_nxt = r_x - w_y_sh;
            w_y_nxt = r_y + w_x_sh;
            w_z_nxt = r_z - w_atan;
        end else begin
            w_x_nxt = r_x + w_y_sh;
            w_y_nxt = r_y - w_x_sh;
            w_z_nxt = r_z + w_atan;
        end
    end

`ifdef CORDIC_VEC_GAIN_COMP_EN
    logic [W-1:0]   w_x_mag;
    logic [W+15:0]  w_prod;
    logic [XY_SZ:0] w_mag_scaled;

    // X is non-negative after pre-rotation, so an unsigned multiply is safe.
    always_comb begin
        w_x_mag      = r_x;
        w_prod       = (W+16)'(w_x_mag) * (W+16)'(CORDIC_K_Q16) + (W+16)'(32'h8000);
        w_mag_scaled = (XY_SZ+1)'(w_prod >> 16);
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_ITER;
                end
            end
            ST_ITER: begin
                if (w_last) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                    w_state_nxt = ST_SCALE;
`else
                    w_state_nxt = ST_DONE;
`endif
                end
            end
            ST_SCALE: w_state_nxt = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered so they stay frozen while the consumer stalls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_cnt  <= '0;
            r_zero <= 1'b0;
            r_mag  <= '0;
            r_ang  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_x    <= w_x_pre;
                        r_y    <= w_y_pre;
                        r_z    <= w_z_pre;
                        r_cnt  <= '0;
                        r_zero <= (Xin == '0) && (Yin == '0);
                    end
                end
                ST_ITER: begin
                    r_x   <= w_x_nxt;
                    r_y   <= w_y_nxt;
                    r_z   <= w_z_nxt;
                    r_cnt <= r_cnt + 5'd1;
                    if (w_last) begin
                        r_ang <= r_zero ? '0 : w_z_nxt;
`ifndef CORDIC_VEC_GAIN_COMP_EN
                        r_mag <= r_zero ? '0 : w_x_nxt[XY_SZ:0];
`endif
                    end
                end
`ifdef CORDIC_VEC_GAIN_COMP_EN
                ST_SCALE: begin
                    r_mag <= r_zero ? '0 : w_mag_scaled;
                end
`endif
                default: ;
            endcase
        end
    end

    assign Mag   = r_mag;
    assign Angle = r_ang;

endmodule

// File: tb/tb_cordic_vector.sv
// Scoreboarded bench for cordic_vector: expected magnitude/angle from real-valued atan2/sqrt,
// checked by an independent output monitor with latency, stall and reset checks.
module tb_cordic_vector;

    localparam int XY_SZ = 16;
    localparam int ITER  = 16;
`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam int  LAT       = ITER + 1;
    localparam real MAG_SCALE = 39797.0 / 65536.0;
    localparam int  MAG_TOL   = 7;
`else
    localparam int  LAT       = ITER;
    localparam real MAG_SCALE = 1.0;
    localparam int  MAG_TOL   = 10;
`endif
    localparam real PI   = 3.14159265358979323846;
    localparam real TURN = 4294967296.0;

    logic                    clock;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [XY_SZ-1:0] Xin;
    logic signed [XY_SZ-1:0] Yin;
    logic                    out_valid;
    logic                    out_ready;
    logic [XY_SZ:0]          Mag;
    logic [31:0]             Angle;

    cordic_vector #(.XY_SZ(XY_SZ), .ITER(ITER)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Xin       (Xin),
        .Yin       (Yin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Mag       (Mag),
        .Angle     (Angle)
    );

    typedef struct {
        int          x;
        int          y;
        int          mag;
        int          mag_tol;
        logic [31:0] ang;
        longint      ang_tol;
        int          acc;
        int          stall;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    real  gain  = 1.0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input longint act, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d, wanted %0d", name, act, req);
        end
    endtask

    // Ideal result: true polar form scaled by the CORDIC gain for ITER steps.
    function automatic exp_t model(input int x, input int y);
        exp_t e;
        real  r;
        real  a;
        e.x     = x;
        e.y     = y;
        e.acc   = 0;
        e.stall = 0;
        r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        if (x == 0 && y == 0) begin
            e.mag = 0; e.mag_tol = 0; e.ang = '0; e.ang_tol = 0;
        end else begin
            e.mag     = int'(r * gain * MAG_SCALE);
            e.mag_tol = MAG_TOL;
            a         = $atan2(real'(y), real'(x)) * TURN / (2.0 * PI);
            e.ang     = 32'(longint'(a));
            e.ang_tol = 131072 + longint'(16.0 / (gain * r) * TURN / (2.0 * PI));
        end
        return e;
    endfunction

    task automatic send(input int x, input int y, input int stall);
        exp_t e;
        int   w = 0;
        @(negedge clock);
        while (!in_ready && w < 300) begin
            @(negedge clock);
            w++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 1'b0, 0, 1);
            return;
        end
        e       = model(x, y);
        e.acc   = cyc + 1;
        e.stall = stall;
        in_valid = 1'b1;
        Xin      = XY_SZ'(x);
        Yin      = XY_SZ'(y);
        exp_q.push_back(e);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(negedge clock);
            w++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 1'b0, exp_q.size(), 0);
    endtask

    // Output monitor: owns out_ready, pops one expectation per handshake.
    initial begin : monitor
        bit          seen = 1'b0;
        int          stall_left = 0;
        logic [XY_SZ:0] hold_mag;
        logic [31:0] hold_ang;
        exp_t        e;
        int          dm;
        logic [31:0] da;
        longint      sda;
        out_ready = 1'b1;
        forever begin
            @(negedge clock);
            if (reset) begin
                seen = 1'b0;
                out_ready = 1'b1;
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1'b0, 1, 0);
                    out_ready = 1'b1;
                end else begin
                    e = exp_q[0];
                    if (!seen) begin
                        seen = 1'b1;
                        chk($sformatf("latency(%0d,%0d)", e.x, e.y), (cyc - e.acc) == LAT, cyc - e.acc, LAT);
                        hold_mag   = Mag;
                        hold_ang   = Angle;
                        stall_left = e.stall;
                    end else begin
                        chk("stall_mag_stable", Mag == hold_mag, Mag, hold_mag);
                        chk("stall_ang_stable", Angle == hold_ang, Angle, hold_ang);
                        chk("stall_in_ready", in_ready == 1'b0, in_ready, 0);
                    end
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                        dm   = int'(Mag) - e.mag;
                        if (dm < 0) dm = -dm;
                        chk($sformatf("mag(%0d,%0d)", e.x, e.y), dm <= e.mag_tol, Mag, e.mag);
                        da  = Angle - e.ang;
                        sda = longint'($signed(da));
                        if (sda < 0) sda = -sda;
                        chk($sformatf("angle(%0d,%0d)", e.x, e.y), sda <= e.ang_tol, Angle, e.ang);
                    end
                end
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        real s;
        int  x;
        int  y;
        s = 1.0;
        for (int i = 0; i < ITER; i++) begin
            gain = gain * $sqrt(1.0 + s);
            s    = s / 4.0;
        end

        reset    = 1'b1;
        in_valid = 1'b0;
        Xin      = '0;
        Yin      = '0;
        @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready",  in_ready == 1'b1, in_ready, 1);
        chk("rst_out_valid", out_valid == 1'b0, out_valid, 0);
        chk("rst_mag",       Mag == '0, Mag, 0);
        chk("rst_angle",     Angle == '0, Angle, 0);
        @(negedge clock);
        reset = 1'b0;

        send(1000, 0, 0);
        send(0, 1000, 0);
        send(-1000, 0, 0);
        send(1000, -1000, 0);
        send(-32768, -32768, 0);
        send(0, 0, 0);
        send(0, -1000, 0);
        send(-1000, -1, 0);
        send(32767, 32767, 0);
        send(-32768, 32767, 0);

        // Consumer stall with in_valid pulses while busy.
        send(300, -700, 10);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            chk("busy_in_ready", in_ready == 1'b0, in_ready, 0);
            in_valid = k[0];
            Xin      = XY_SZ'($urandom);
            Yin      = XY_SZ'($urandom);
        end
        in_valid = 1'b0;
        drain();

        // Reset while iterating: result discarded, engine immediately idle.
        send(1234, -567, 0);
        repeat (5) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid == 1'b0, out_valid, 0);
        chk("midrst_in_ready",  in_ready == 1'b1, in_ready, 1);
        chk("midrst_mag",       Mag == '0, Mag, 0);
        chk("midrst_angle",     Angle == '0, Angle, 0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        send(500, 500, 0);

        for (int n = 0; n < 20; n++) begin
            do begin
                x = int'($urandom_range(65535)) - 32768;
                y = int'($urandom_range(65535)) - 32768;
            end while (real'(x) * real'(x) + real'(y) * real'(y) < 262144.0);
            send(x, y, 0);
        end

        drain();
        repeat (ITER + 4) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
